// File: rtl/psum_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : psum_accumulator
//  Description : Two-stage saturating partial-sum accumulator with an
//                addressable buffer and a valid/ready result port.
//  Revision    : 1.0 - initial release
// ============================================================================
module psum_accumulator #(
    parameter int IN_WIDTH   = 32,
    parameter int ACC_WIDTH  = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_first,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic                  out_sat
);

    localparam logic [ACC_WIDTH-1:0] c_sat_max = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] c_sat_min = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam int                   c_ext_w   = ACC_WIDTH + 1 - IN_WIDTH;

    logic [ACC_WIDTH-1:0]  psum_mem_q [DEPTH];
    logic                  sat_mem_q  [DEPTH];

    logic                  s1_valid_q, s1_valid_d;
    logic [ADDR_WIDTH-1:0] s1_addr_q,  s1_addr_d;
    logic [IN_WIDTH-1:0]   s1_data_q,  s1_data_d;
    logic                  s1_first_q, s1_first_d;
    logic                  s1_last_q,  s1_last_d;
    logic [ACC_WIDTH-1:0]  s1_rdata_q, s1_rdata_d;
    logic                  s1_rsat_q,  s1_rsat_d;

    logic                  fwd_valid_q, fwd_valid_d;
    logic [ADDR_WIDTH-1:0] fwd_addr_q,  fwd_addr_d;
    logic [ACC_WIDTH-1:0]  fwd_sum_q,   fwd_sum_d;
    logic                  fwd_sat_q,   fwd_sat_d;

    logic                  out_valid_q, out_valid_d;
    logic [ADDR_WIDTH-1:0] out_addr_q,  out_addr_d;
    logic [ACC_WIDTH-1:0]  out_data_q,  out_data_d;
    logic                  out_sat_q,   out_sat_d;

    logic                  adv;
    logic                  retire;
    logic                  mem_we;
    logic [ACC_WIDTH-1:0]  operand;
    logic                  op_sat;
    logic [ACC_WIDTH:0]    sum_wide;
    logic [ACC_WIDTH-1:0]  sum;
    logic                  sat_bit;
    logic                  sticky;

    always_comb begin
        adv    = !(out_valid_q && !out_ready);
        retire = adv && s1_valid_q;
        mem_we = retire && !reset;

        s1_valid_d = s1_valid_q;
        s1_addr_d  = s1_addr_q;
        s1_data_d  = s1_data_q;
        s1_first_d = s1_first_q;
        s1_last_d  = s1_last_q;
        s1_rdata_d = s1_rdata_q;
        s1_rsat_d  = s1_rsat_q;
        if (adv) begin
            s1_valid_d = in_valid;
            s1_addr_d  = in_addr;
            s1_data_d  = in_data;
            s1_first_d = in_first;
            s1_last_d  = in_last;
            s1_rdata_d = psum_mem_q[in_addr];
            s1_rsat_d  = sat_mem_q[in_addr];
        end

        // The buffer read for this item raced the write of the item retired
        // on the same edge; the fwd_* copy of that write supersedes it.
        if (s1_first_q) begin
            operand = '0;
            op_sat  = 1'b0;
        end else if (fwd_valid_q && (fwd_addr_q == s1_addr_q)) begin
            operand = fwd_sum_q;
            op_sat  = fwd_sat_q;
        end else begin
            operand = s1_rdata_q;
            op_sat  = s1_rsat_q;
        end

        sum_wide = {operand[ACC_WIDTH-1], operand}
                 + {{c_ext_w{s1_data_q[IN_WIDTH-1]}}, s1_data_q};
        if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]) begin
            sat_bit = 1'b1;
            sum     = sum_wide[ACC_WIDTH] ? c_sat_min : c_sat_max;
        end else begin
            sat_bit = 1'b0;
            sum     = sum_wide[ACC_WIDTH-1:0];
        end
        sticky = s1_first_q ? sat_bit : (op_sat | sat_bit);

        fwd_valid_d = fwd_valid_q;
        fwd_addr_d  = fwd_addr_q;
        fwd_sum_d   = fwd_sum_q;
        fwd_sat_d   = fwd_sat_q;
        if (adv) begin
            fwd_valid_d = s1_valid_q;
            fwd_addr_d  = s1_addr_q;
            fwd_sum_d   = sum;
            fwd_sat_d   = sticky;
        end

        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (adv) begin
            out_valid_d = s1_valid_q && s1_last_q;
            if (retire && s1_last_q) begin
                out_addr_d = s1_addr_q;
                out_data_d = sum;
                out_sat_d  = sticky;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            psum_mem_q[s1_addr_q] <= sum;
            sat_mem_q[s1_addr_q]  <= sticky;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            s1_data_q   <= '0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_rdata_q  <= '0;
            s1_rsat_q   <= 1'b0;
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_sum_q   <= '0;
            fwd_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_addr_q   <= s1_addr_d;
            s1_data_q   <= s1_data_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            s1_rdata_q  <= s1_rdata_d;
            s1_rsat_q   <= s1_rsat_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_addr_q  <= fwd_addr_d;
            fwd_sum_q   <= fwd_sum_d;
            fwd_sat_q   <= fwd_sat_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_psum_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psum_accumulator
//  Description : Self-checking bench for psum_accumulator (IN=8, ACC=16, DEPTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psum_accumulator;

    localparam int c_in_w  = 8;
    localparam int c_acc_w = 16;
    localparam int c_depth = 4;
    localparam int c_aw    = 2;
    localparam int c_max   = 32767;
    localparam int c_min   = -32768;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [c_aw-1:0]   in_addr = '0;
    logic [c_in_w-1:0] in_data = '0;
    logic              in_first = 1'b0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [c_aw-1:0]   out_addr;
    logic [c_acc_w-1:0] out_data;
    logic              out_sat;

    psum_accumulator #(
        .IN_WIDTH  (c_in_w),
        .ACC_WIDTH (c_acc_w),
        .DEPTH     (c_depth),
        .ADDR_WIDTH(c_aw)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .in_first (in_first),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_addr (out_addr),
        .out_data (out_data),
        .out_sat  (out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        bit sat;
    } res_t;

    res_t exp_q[$];
    res_t got_q[$];
    res_t r_got;
    res_t r_exp;
    int   m_sum[c_depth];
    bit   m_sat[c_depth];
    int   checks = 0;
    int   errors = 0;
    bit   rand_ready = 1'b0;
    bit   ready_force = 1'b1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Reference: plain integer accumulation with clamping per address.
    task automatic model_accept(input int a, input int d, input bit f, input bit l);
        int s;
        bit sb;
        s  = (f ? 0 : m_sum[a]) + d;
        sb = 1'b0;
        if (s > c_max) begin
            s  = c_max;
            sb = 1'b1;
        end else if (s < c_min) begin
            s  = c_min;
            sb = 1'b1;
        end
        m_sat[a] = f ? sb : (m_sat[a] | sb);
        m_sum[a] = s;
        if (l) begin
            r_exp.addr = a;
            r_exp.data = s;
            r_exp.sat  = m_sat[a];
            exp_q.push_back(r_exp);
        end
    endtask

    always @(posedge clk) begin
        #2;
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            check("in_ready_rule", int'(in_ready), int'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                r_got.addr = int'(out_addr);
                r_got.data = int'($signed(out_data));
                r_got.sat  = out_sat;
                got_q.push_back(r_got);
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    r_exp = exp_q.pop_front();
                    check("out_addr", r_got.addr, r_exp.addr);
                    check("out_data", r_got.data, r_exp.data);
                    check("out_sat", int'(r_got.sat), int'(r_exp.sat));
                end
            end
            if (in_valid && in_ready)
                model_accept(int'(in_addr), int'($signed(in_data)), in_first, in_last);
        end
    end

    initial begin
        repeat (30000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int a, input int d, input bit f, input bit l);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        in_addr  = a[c_aw-1:0];
        in_data  = d[c_in_w-1:0];
        in_first = f;
        in_last  = l;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_ready;
            tick();
            n++;
        end
        if (!ok) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic check_got(input string tag, input int idx, input int a, input int d, input bit s);
        if (got_q.size() <= idx) begin
            check($sformatf("%s_missing", tag), got_q.size(), idx + 1);
        end else begin
            check($sformatf("%s_addr", tag), got_q[idx].addr, a);
            check($sformatf("%s_data", tag), got_q[idx].data, d);
            check($sformatf("%s_sat", tag), int'(got_q[idx].sat), int'(s));
        end
    endtask

    bit primed[c_depth];

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_addr", int'(out_addr), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_sat", int'(out_sat), 0);
        check("rst_in_ready", int'(in_ready), 1);
        tick();

        // Back-to-back same-address beats with latency check.
        got_q.delete();
        send(1, 5, 1, 0);
        send(1, -3, 0, 0);
        send(1, 10, 0, 1);
        @(negedge clk);
        check("t1_lat_early", int'(out_valid), 0);
        @(negedge clk);
        check("t1_lat_valid", int'(out_valid), 1);
        check("t1_addr", int'(out_addr), 1);
        check("t1_data", int'($signed(out_data)), 12);
        check("t1_sat", int'(out_sat), 0);
        repeat (3) tick();
        check("t1_count", got_q.size(), 1);

        // Interleaved addresses.
        got_q.delete();
        send(0, 100, 1, 0);
        send(1, -7, 1, 0);
        send(0, 27, 0, 1);
        send(1, -1, 0, 1);
        repeat (4) tick();
        check("t2_count", got_q.size(), 2);
        check_got("t2_a", 0, 0, 127, 1'b0);
        check_got("t2_b", 1, 1, -8, 1'b0);

        // Positive and negative saturation, then sticky cleared by first.
        got_q.delete();
        send(2, 127, 1, 0);
        for (int i = 0; i < 299; i++) send(2, 127, 0, 0);
        send(2, 127, 0, 1);
        send(3, -128, 1, 0);
        for (int i = 0; i < 299; i++) send(3, -128, 0, 0);
        send(3, -128, 0, 1);
        send(2, 1, 1, 1);
        send(0, -128, 1, 1);
        repeat (4) tick();
        check("t3_count", got_q.size(), 4);
        check_got("t3_pos", 0, 2, 32767, 1'b1);
        check_got("t3_neg", 1, 3, -32768, 1'b1);
        check_got("t3_clr", 2, 2, 1, 1'b0);
        check_got("t3_fl", 3, 0, -128, 1'b0);

        // Backpressure with two pending results.
        got_q.delete();
        ready_force = 1'b0;
        tick();
        send(0, 5, 1, 1);
        send(1, 6, 1, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_in_ready", int'(in_ready), 0);
            check("t4_hold_valid", int'(out_valid), 1);
            check("t4_hold_addr", int'(out_addr), 0);
            check("t4_hold_data", int'($signed(out_data)), 5);
            tick();
        end
        ready_force = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("t4_next_valid", int'(out_valid), 1);
        check("t4_next_addr", int'(out_addr), 1);
        check("t4_next_data", int'($signed(out_data)), 6);
        repeat (3) tick();
        check("t4_count", got_q.size(), 2);
        check_got("t4_a", 0, 0, 5, 1'b0);
        check_got("t4_b", 1, 1, 6, 1'b0);

        // Reset one cycle after a last beat is accepted.
        got_q.delete();
        send(1, 9, 1, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_no_valid", int'(out_valid), 0);
            check("t5_in_ready", int'(in_ready), 1);
            tick();
        end
        check("t5_count0", got_q.size(), 0);
        send(3, 4, 1, 1);
        repeat (3) tick();
        check("t5_count1", got_q.size(), 1);
        check_got("t5_out", 0, 3, 4, 1'b0);

        // Random beats with random backpressure against the model.
        rand_ready = 1'b1;
        for (int i = 0; i < c_depth; i++) primed[i] = 1'b0;
        for (int i = 0; i < 250; i++) begin
            int a;
            bit f;
            a = $urandom_range(0, c_depth - 1);
            f = !primed[a] || ($urandom_range(0, 4) == 0);
            primed[a] = 1'b1;
            send(a, $urandom_range(0, 255) - 128, f, $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) tick();
        end
        rand_ready = 1'b0;
        ready_force = 1'b1;
        repeat (10) tick();
        check("drain_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Downstream consumer of the signed adder / MAC array output: accumulates a stream of signed partial products into a small addressable partial-sum buffer.
- Each input beat is tagged with a buffer address plus first/last flags.
- When a beat carries last, the final saturated sum for that address is emitted on a valid/ready output port toward the output buffer / activation stage.
- Two-stage pipeline (registered buffer read, then saturating add with write-back), with forwarding for back-to-back hits on the same address.

Parameters:
- IN_WIDTH, 32: signed width of incoming partial product.
- ACC_WIDTH, 32: signed width of stored/emitted sum; must be >= IN_WIDTH.
- DEPTH, 16: number of partial-sum entries; power of two, >= 2.
- ADDR_WIDTH, 4: log2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_addr  input  ADDR_WIDTH  partial-sum entry index.
- in_data  input  IN_WIDTH  signed partial product.
- in_first  input  1  beat starts a new sum (operand treated as 0).
- in_last  input  1  beat completes the sum; result is emitted.
- out_valid  output  1  emitted sum valid.
- out_ready  input  1  downstream accepts the emitted sum.
- out_addr  output  ADDR_WIDTH  entry index of the emitted sum.
- out_data  output  ACC_WIDTH  signed saturated final sum.
- out_sat  output  1  saturation occurred on any beat of this sum.

Behaviour:
- Stall and accept:
  - adv = !(out_valid && !out_ready); in_ready = adv.
  - A beat is accepted when in_valid && in_ready.
  - When adv = 0, S1, S2 and the output register all hold their contents.
- S1 (cycle of acceptance +1): registers addr/data/first/last/valid and performs a registered read of buf[addr].
- S2 operand selection:
  - 0 if first.
  - Otherwise S2's previous sum, if the S2 item being retired in the same advance wrote the same addr (forwarding).
  - Otherwise the registered read data.
- S2 arithmetic:
  - sum = operand + sign-extended in_data, computed at ACC_WIDTH+1 bits.
  - Clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - sat_bit = 1 if clamped.
  - Per-entry sticky sat flag: set to sat_bit on first, OR-ed on later beats.
- S2 retire (on adv, when S2 valid):
  - buf[addr] <= sum; sticky flag updated.
  - If last: out_valid <= 1, out_addr, out_data = sum, out_sat = sticky | sat_bit.
  - Else: out_valid <= 0 (if out_ready consumed it).
- Latency: a last beat accepted in cycle N gives out_valid=1 in cycle N+2 when unstalled. Throughput is 1 beat/cycle for any address sequence, including repeated addresses.
- Output register: holds out_addr/out_data/out_sat stable while out_valid && !out_ready. It clears to out_valid=0 on a handshake when no new last beat retires that cycle.
- Beats with both first and last set emit sat(in_data) directly.
- Buffer contents and sticky flags are not reset. The first beat to any entry must carry in_first; an un-primed entry yields an undefined sum (verification does not check it).
- Reset:
  - out_valid=0, out_addr=0, out_data=0, out_sat=0, S1/S2 valid=0; in_ready=1 in the cycle after reset deasserts.
  - Reset mid-operation discards all in-flight beats; no output is produced for them.
- Simultaneous events: output handshake and new last retire in the same cycle → the new result replaces the old one with out_valid held at 1.

Test Plan:
- IN=8, ACC=16, DEPTH=4. Beats addr1: {5 first}, {-3}, {10 last} back-to-back → one output, 2 cycles after the last beat: addr=1, data=12, sat=0.
- Interleaved addr0 {100 first}, addr1 {-7 first}, addr0 {27 last}, addr1 {-1 last} → outputs (0,127), then (1,-8).
- Saturation: addr2 {127 first} followed by 300 beats of +127, last on the final beat → data=32767, sat=1. Negative mirror with -128 → -32768, sat=1.
- Backpressure: out_ready=0 with two last results pending → in_ready=0, out_data stays at the first result until out_ready=1, then the second result appears next cycle; no beat is lost or duplicated.
- Reset asserted one cycle after a last beat is accepted → out_valid stays 0. A subsequent addr3 {4 first last} → (3,4).
- Random beats with random valid/ready and a reference model: all emitted sums and flags match.
